// File: rtl/smi_pkg.sv
// Shared SMI definitions: EOFC encoding and the request-side frame state.
package smi_pkg;

  localparam int unsigned EOFC_W = 8;
  localparam logic [EOFC_W-1:0] EOFC_MID = 8'h00;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } req_state_e;

  // Any non-zero EOFC marks the last flit of a frame.
  function automatic logic is_eof(input logic [EOFC_W-1:0] eofc);
    return eofc != EOFC_MID;
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry registered SMI flit buffer; the full flag is registered so the
// upstream Stop never depends combinationally on the downstream Stop.
module smi_skid_buffer
  import smi_pkg::*;
#(
  parameter  int unsigned FlitWidth = 4,
  localparam int unsigned DataWidth = FlitWidth * 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 push_i,
  input  logic [EOFC_W-1:0]    push_eofc_i,
  input  logic [DataWidth-1:0] push_data_i,
  output logic                 full_o,
  output logic                 out_ready_o,
  output logic [EOFC_W-1:0]    out_eofc_o,
  output logic [DataWidth-1:0] out_data_o,
  input  logic                 out_stop_i
);

  logic [EOFC_W-1:0]    eofc_q [2];
  logic [DataWidth-1:0] data_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           cnt_q, cnt_d;
  logic                 full_q, valid_q;
  logic                 pop;

  assign pop   = valid_q && !out_stop_i;
  assign cnt_d = cnt_q + 2'(push_i) - 2'(pop);

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_q ^ pop;
      wr_ptr_q <= wr_ptr_q ^ push_i;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == 2'd2);
      valid_q  <= (cnt_d != 2'd0);
    end
  end

  // Payload storage needs no reset; valid_q qualifies it.
  always_ff @(posedge clk) begin
    if (push_i) begin
      eofc_q[wr_ptr_q] <= push_eofc_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign full_o      = full_q;
  assign out_ready_o = valid_q;
  assign out_eofc_o  = eofc_q[rd_ptr_q];
  assign out_data_o  = data_q[rd_ptr_q];

endmodule

// File: rtl/smi_transaction_throttle.sv
// Caps outstanding SMI transactions: request frames open one at SOF,
// response frames close one at their final flit.
module smi_transaction_throttle
  import smi_pkg::*;
#(
  parameter  int unsigned FlitWidth   = 4,
  parameter  int unsigned MaxInFlight = 8,
  parameter  int unsigned CountWidth  = 8,
  localparam int unsigned DataWidth   = FlitWidth * 8
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  smiReqInReady,
  input  logic [EOFC_W-1:0]     smiReqInEofc,
  input  logic [DataWidth-1:0]  smiReqInData,
  output logic                  smiReqInStop,
  output logic                  smiReqOutReady,
  output logic [EOFC_W-1:0]     smiReqOutEofc,
  output logic [DataWidth-1:0]  smiReqOutData,
  input  logic                  smiReqOutStop,
  input  logic                  smiRespInReady,
  input  logic [EOFC_W-1:0]     smiRespInEofc,
  input  logic [DataWidth-1:0]  smiRespInData,
  output logic                  smiRespInStop,
  output logic                  smiRespOutReady,
  output logic [EOFC_W-1:0]     smiRespOutEofc,
  output logic [DataWidth-1:0]  smiRespOutData,
  input  logic                  smiRespOutStop,
  output logic [CountWidth-1:0] inFlightCount,
  output logic                  throttled,
  output logic                  underflowErr
);

  req_state_e            state_q, state_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  err_q, err_d;
  logic                  buf_full, at_limit, req_accept, sof, resp_eof;

  assign at_limit   = (count_q == CountWidth'(MaxInFlight));
  assign smiReqInStop = srst || buf_full || ((state_q == IDLE) && at_limit);
  assign throttled  = !srst && (state_q == IDLE) && at_limit;
  assign req_accept = smiReqInReady && !smiReqInStop;
  assign sof        = req_accept && (state_q == IDLE);
  assign resp_eof   = smiRespInReady && !smiRespOutStop && is_eof(smiRespInEofc);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Frame tracking and in-flight accounting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    if (req_accept) begin
      state_d = is_eof(smiReqInEofc) ? IDLE : IN_FRAME;
    end
    unique case ({sof, resp_eof})
      2'b10: count_d = count_q + CountWidth'(1);
      2'b01: begin
        if (count_q == '0) err_d = 1'b1;
        else               count_d = count_q - CountWidth'(1);
      end
      default: ;
    endcase
  end

  smi_skid_buffer #(.FlitWidth(FlitWidth)) u_req_skid (
    .clk         (clk),
    .srst        (srst),
    .push_i      (req_accept),
    .push_eofc_i (smiReqInEofc),
    .push_data_i (smiReqInData),
    .full_o      (buf_full),
    .out_ready_o (smiReqOutReady),
    .out_eofc_o  (smiReqOutEofc),
    .out_data_o  (smiReqOutData),
    .out_stop_i  (smiReqOutStop)
  );

  assign smiRespOutReady = smiRespInReady;
  assign smiRespOutEofc  = smiRespInEofc;
  assign smiRespOutData  = smiRespInData;
  assign smiRespInStop   = smiRespOutStop;

  assign inFlightCount = count_q;
  assign underflowErr  = err_q;

endmodule

// File: doc/smi_transaction_throttle.md
Name: smi_transaction_throttle

Overview:
- Sits between the four-way transaction arbiter's downstream request/response ports and the memory-side SMI endpoint.
- Limits the number of outstanding request frames (transactions) in flight to the endpoint. Each request frame opens one transaction and each response frame closes one.
- Request path has a 2-entry skid buffer that registers the output and breaks the Stop timing path. Response path is a combinational pass-through.

Parameters:
- FlitWidth, 4, flit width in bytes; must be at least 4.
- DataWidth, FlitWidth*8, derived data port width.
- MaxInFlight, 8, maximum outstanding transactions; range 1..255.
- CountWidth, 8, width of the in-flight counter; must satisfy 2^CountWidth > MaxInFlight.

Ports:
- clk  in  1  system clock
- srst  in  1  synchronous active-high reset
- smiReqInReady  in  1  upstream request flit valid
- smiReqInEofc  in  8  upstream request end-of-frame control
- smiReqInData  in  DataWidth  upstream request flit data
- smiReqInStop  out  1  backpressure to upstream request
- smiReqOutReady  out  1  downstream request flit valid
- smiReqOutEofc  out  8  downstream request EOFC
- smiReqOutData  out  DataWidth  downstream request data
- smiReqOutStop  in  1  backpressure from endpoint
- smiRespInReady  in  1  response flit valid from endpoint
- smiRespInEofc  in  8  response EOFC
- smiRespInData  in  DataWidth  response data
- smiRespInStop  out  1  backpressure to endpoint
- smiRespOutReady  out  1  response flit valid to arbiter
- smiRespOutEofc  out  8  response EOFC
- smiRespOutData  out  DataWidth  response data
- smiRespOutStop  in  1  backpressure from arbiter
- inFlightCount  out  CountWidth  current outstanding transactions
- throttled  out  1  high when request start is blocked by the limit
- underflowErr  out  1  sticky: response closed with count already zero

Behaviour:
- Handshake and framing:
  - A flit transfers on the cycle Ready=1 and Stop=0.
  - EOFC=0 marks a mid-frame flit. EOFC≠0 marks the final flit of a frame.
- Reset (srst=1 at a clock edge, including mid-frame):
  - Count and error flag cleared, state set to IDLE, skid buffer emptied.
  - smiReqOutReady=0, smiReqInStop=1 during reset, inFlightCount=0, throttled=0, underflowErr=0.
  - Response passthrough is unaffected combinationally.
- Request input FSM:
  - IDLE: the first flit of a frame is accepted only if count<MaxInFlight and the skid buffer is not full.
    - Accepting a flit with EOFC=0 moves to IN_FRAME.
    - Accepting a flit with EOFC≠0 (single-flit frame) stays in IDLE.
  - IN_FRAME: flits are gated only by skid-buffer space, never by the limit.
    - Accepting the final flit returns to IDLE.
  - An increment is generated on the accepted flit in IDLE, i.e. start of frame.
- throttled is combinational: state==IDLE and count==MaxInFlight.
- smiReqInStop = skid buffer full, OR (IDLE and count==MaxInFlight).
- Skid buffer:
  - 2 entries, FIFO order, latency 1 cycle from acceptance to smiReqOutReady.
  - Full throughput of 1 flit per cycle when downstream does not stall.
  - Output Ready, Eofc and Data come directly from registers and stay stable while Stop=1.
- Response path:
  - smiRespOutReady/Eofc/Data equal smiRespIn*.
  - smiRespInStop = smiRespOutStop.
  - A decrement is generated on a transferred response flit with EOFC≠0.
- Counter update, once per cycle:
  - increment only: +1
  - decrement only: −1
  - both: unchanged
  - decrement at count=0 with no increment: count stays 0 and underflowErr is set; it clears only on srst.
  - Count can never exceed MaxInFlight by construction.
- Counting response frames at the final flit lets a new request start in the cycle after a response completes (1-cycle reopen latency).

Decomposition:
- Shared package smi_pkg holds:
  - EOFC encoding constant (EOFC_MID=0).
  - Request FSM state enum {IDLE, IN_FRAME}.
- One natural sub-module: smi_skid_buffer (2-entry registered SMI flit buffer, parameterised by FlitWidth). It is reusable by the other SMI stages.
- The counter and FSM stay in the top level.

Test Plan:
- MaxInFlight=2; send 3 single-flit requests back-to-back with the endpoint never responding.
  - Required: two forwarded with inFlightCount=2.
  - Required: third held with smiReqInStop=1 and throttled=1.
  - Required: one single-flit response releases the third request on the next cycle; count returns to 2.
- 4-flit request at count=MaxInFlight−1.
  - Required: all 4 flits pass without stall; count becomes MaxInFlight only once.
  - Required: the next SOF is blocked.
- Request SOF acceptance and response EOF in the same cycle at count=1.
  - Required: count stays 1.
- Hold smiReqOutStop=1 for 5 cycles mid-stream.
  - Required: at most 2 flits buffered.
  - Required: smiReqOutData is stable throughout the stall.
  - Required: no flit is lost or reordered after release.
- Response EOF with count=0.
  - Required: underflowErr=1 and count=0.
  - Required: the error persists until srst, then reads 0.
- Assert srst in the middle of a 3-flit request with count=3.
  - Required: next cycle count=0, smiReqOutReady=0 and state IDLE.
  - Required: after reset the next SOF is accepted normally.
